program_loader: RTL

PROGRAM_LOADER -- requirements
Module: program_loader

---
 rtl/program_loader.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/program_loader.sv
// rtl/program_loader.sv - byte-stream program loader writing 32-bit words into program memory
//
// Purpose: receives a length-prefixed byte stream (16-bit big-endian word count
// followed by big-endian 32-bit words), writes each word into program memory at
// BASE_ADDRESS + 4*index, and holds the CPU in reset until loading is complete.
// Optional feature macro: LOADER_CHECKSUM_EN (adds CHECK state and 8-bit sum).
//
// Ports:
//   clk          - clock, rising edge
//   reset        - synchronous active-high reset
//   byte_i       - incoming stream byte
//   byte_valid_i - byte_i valid
//   byte_ready_o - loader accepts byte_i this cycle
//   reload_i     - restart loading from DONE or ERROR
//   wr_en_o      - one-cycle program-memory write strobe
//   wr_addr_o    - byte address of the write
//   wr_data_o    - assembled instruction word
//   cpu_hold_o   - holds the CPU in reset while loading
//   done_o       - load completed successfully
//   error_o      - load aborted
module program_loader #(
  parameter int                    MEMORY_DEPTH = 32,
  parameter int                    DATA_WIDTH   = 32,
  parameter logic [DATA_WIDTH-1:0] BASE_ADDRESS = 32'h400000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [7:0]            byte_i,
  input  logic                  byte_valid_i,
  output logic                  byte_ready_o,
  input  logic                  reload_i,
  output logic                  wr_en_o,
  output logic [DATA_WIDTH-1:0] wr_addr_o,
  output logic [DATA_WIDTH-1:0] wr_data_o,
  output logic                  cpu_hold_o,
  output logic                  done_o,
  output logic                  error_o
);

  localparam int IDX_W = $clog2(MEMORY_DEPTH + 1);

`ifdef LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {LEN_HI, LEN_LO, DATA, CHECK, DONE, ERROR} state_t;
`else
  typedef enum logic [2:0] {LEN_HI, LEN_LO, DATA, DONE, ERROR} state_t;
`endif

  state_t                state;
  logic [7:0]            len_hi;
  logic [15:0]           len;
  logic [IDX_W-1:0]      idx;
  logic [1:0]            byte_cnt;
  // Only the first three bytes of a word need holding; the fourth goes
  // straight into wr_data_o together with them.
  logic [DATA_WIDTH-9:0] word_buf;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]            sum;
`endif

  logic                  fire;
  logic [15:0]           len_next;
  logic [15:0]           written_count;
  logic [DATA_WIDTH-1:0] word_next;

  assign fire          = byte_valid_i & byte_ready_o;
  assign len_next      = {len_hi, byte_i};
  assign written_count = 16'(idx) + 16'd1;
  assign word_next     = {word_buf, byte_i};

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= LEN_HI;
      len_hi       <= 8'd0;
      len          <= 16'd0;
      idx          <= '0;
      byte_cnt     <= 2'd0;
      word_buf     <= '0;
      wr_en_o      <= 1'b0;
      wr_addr_o    <= BASE_ADDRESS;
      wr_data_o    <= '0;
      byte_ready_o <= 1'b1;
      cpu_hold_o   <= 1'b1;
      done_o       <= 1'b0;
      error_o      <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      sum          <= 8'd0;
`endif
    end else begin
      wr_en_o <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      if (fire && (state == LEN_HI || state == LEN_LO || state == DATA)) begin
        sum <= sum + byte_i;
      end
`endif
      case (state)
        LEN_HI: begin
          if (fire) begin
            len_hi <= byte_i;
            state  <= LEN_LO;
          end
        end

        LEN_LO: begin
          if (fire) begin
            len <= len_next;
            if (len_next == 16'd0) begin
`ifdef LOADER_CHECKSUM_EN
              state <= CHECK;
`else
              state        <= DONE;
              byte_ready_o <= 1'b0;
              cpu_hold_o   <= 1'b0;
              done_o       <= 1'b1;
`endif
            end else if (32'(len_next) > 32'(MEMORY_DEPTH)) begin
              state        <= ERROR;
              byte_ready_o <= 1'b0;
              error_o      <= 1'b1;
            end else begin
              state <= DATA;
            end
          end
        end

        DATA: begin
          if (wr_en_o) begin
            // Write cycle: input was stalled, now advance the index.
            idx <= idx + IDX_W'(1);
            if (written_count == len) begin
`ifdef LOADER_CHECKSUM_EN
              state        <= CHECK;
              byte_ready_o <= 1'b1;
`else
              state       <= DONE;
              cpu_hold_o  <= 1'b0;
              done_o      <= 1'b1;
`endif
            end else begin
              byte_ready_o <= 1'b1;
            end
          end else if (fire) begin
            word_buf <= word_next[DATA_WIDTH-9:0];
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              wr_en_o      <= 1'b1;
              wr_data_o    <= word_next;
              wr_addr_o    <= BASE_ADDRESS + (DATA_WIDTH'(idx) << 2);
              byte_ready_o <= 1'b0;
            end
          end
        end

`ifdef LOADER_CHECKSUM_EN
        CHECK: begin
          if (fire) begin
            byte_ready_o <= 1'b0;
            // Check byte is the two's complement of the sum, so they add to zero.
            if (8'(sum + byte_i) == 8'd0) begin
              state      <= DONE;
              cpu_hold_o <= 1'b0;
              done_o     <= 1'b1;
            end else begin
              state   <= ERROR;
              error_o <= 1'b1;
            end
          end
        end
`endif

        DONE, ERROR: begin
          if (reload_i) begin
            state        <= LEN_HI;
            idx          <= '0;
            byte_cnt     <= 2'd0;
            len          <= 16'd0;
            byte_ready_o <= 1'b1;
            cpu_hold_o   <= 1'b1;
            done_o       <= 1'b0;
            error_o      <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            sum          <= 8'd0;
`endif
          end
        end

        default: state <= LEN_HI;
      endcase
    end
  end

endmodule
